// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: turns PS/2 scan-code bytes from the receiver FIFO into
// single-cycle key events, owns the FIFO pop strobe, filters typematic
// repeats of the held key and counts key presses.
// Build option: define PS2_ASCII_EN to compile in the scan-code to ASCII table.
module ps2_key_decoder #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       ps2_data,
    input  logic             ps2_ready,
    input  logic             ps2_overflow,
    output logic             nextdata_n,
    output logic             key_valid,
    output logic [7:0]       key_code,
    output logic             key_ext,
    output logic             key_make,
    output logic [7:0]       key_ascii,
    output logic             key_down,
    output logic [CNT_W-1:0] press_cnt,
    output logic             err
);

    typedef enum logic [1:0] {
        IDLE,
        POP,
        PROC,
        GAP
    } state_t;

    state_t           state_q, state_d;
    logic [7:0]       byte_q, byte_d;
    logic             ext_pend_q, ext_pend_d;
    logic             brk_pend_q, brk_pend_d;
    logic [7:0]       held_code_q, held_code_d;
    logic             held_ext_q, held_ext_d;
    logic             nextdata_n_q, nextdata_n_d;
    logic             key_valid_q, key_valid_d;
    logic [7:0]       key_code_q, key_code_d;
    logic             key_ext_q, key_ext_d;
    logic             key_make_q, key_make_d;
    logic [7:0]       key_ascii_q, key_ascii_d;
    logic             key_down_q, key_down_d;
    logic [CNT_W-1:0] press_cnt_q, press_cnt_d;
    logic             err_q, err_d;
    logic             emit;
    logic             same_key;

`ifdef PS2_ASCII_EN
    // Lowercase scan-code set 2 to ASCII; unknown codes give 0x00.
    function automatic logic [7:0] to_ascii(input logic [7:0] code);
        case (code)
            8'h1C: return 8'h61; 8'h32: return 8'h62; 8'h21: return 8'h63;
            8'h23: return 8'h64; 8'h24: return 8'h65; 8'h2B: return 8'h66;
            8'h34: return 8'h67; 8'h33: return 8'h68; 8'h43: return 8'h69;
            8'h3B: return 8'h6A; 8'h42: return 8'h6B; 8'h4B: return 8'h6C;
            8'h3A: return 8'h6D; 8'h31: return 8'h6E; 8'h44: return 8'h6F;
            8'h4D: return 8'h70; 8'h15: return 8'h71; 8'h2D: return 8'h72;
            8'h1B: return 8'h73; 8'h2C: return 8'h74; 8'h3C: return 8'h75;
            8'h2A: return 8'h76; 8'h1D: return 8'h77; 8'h22: return 8'h78;
            8'h35: return 8'h79; 8'h1A: return 8'h7A;
            8'h45: return 8'h30; 8'h16: return 8'h31; 8'h1E: return 8'h32;
            8'h26: return 8'h33; 8'h25: return 8'h34; 8'h2E: return 8'h35;
            8'h36: return 8'h36; 8'h3D: return 8'h37; 8'h3E: return 8'h38;
            8'h46: return 8'h39;
            8'h29: return 8'h20;
            8'h5A: return 8'h0D;
            default: return 8'h00;
        endcase
    endfunction
`endif

    assign same_key = (byte_q == held_code_q) && (ext_pend_q == held_ext_q);

    // Next-state and output computation. The byte is classified while in POP
    // so that the registered event outputs are visible during PROC.
    always_comb begin
        state_d      = state_q;
        byte_d       = byte_q;
        ext_pend_d   = ext_pend_q;
        brk_pend_d   = brk_pend_q;
        held_code_d  = held_code_q;
        held_ext_d   = held_ext_q;
        nextdata_n_d = 1'b1;
        key_valid_d  = 1'b0;
        key_code_d   = key_code_q;
        key_ext_d    = key_ext_q;
        key_make_d   = key_make_q;
        key_ascii_d  = key_ascii_q;
        key_down_d   = key_down_q;
        press_cnt_d  = press_cnt_q;
        err_d        = err_q | ps2_overflow;
        emit         = 1'b0;

        case (state_q)
            IDLE: begin
                if (ps2_ready) begin
                    byte_d       = ps2_data;
                    nextdata_n_d = 1'b0;
                    state_d      = POP;
                end
            end
            POP: begin
                state_d = PROC;
                case (byte_q)
                    8'hE0: ext_pend_d = 1'b1;
                    8'hF0: brk_pend_d = 1'b1;
                    8'h00, 8'hFF: begin
                        ext_pend_d = 1'b0;
                        brk_pend_d = 1'b0;
                    end
                    default: begin
                        ext_pend_d = 1'b0;
                        brk_pend_d = 1'b0;
                        if (!brk_pend_q) begin
                            // A make of the held key is a typematic repeat.
                            if (!(key_down_q && same_key)) begin
                                emit        = 1'b1;
                                press_cnt_d = press_cnt_q + CNT_W'(1);
                                held_code_d = byte_q;
                                held_ext_d  = ext_pend_q;
                                key_down_d  = 1'b1;
                            end
                        end else begin
                            emit = 1'b1;
                            if (same_key) begin
                                key_down_d = 1'b0;
                            end
                        end
                    end
                endcase
            end
            PROC: state_d = GAP;
            GAP:  state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (emit) begin
            key_valid_d = 1'b1;
            key_code_d  = byte_q;
            key_ext_d   = ext_pend_q;
            key_make_d  = ~brk_pend_q;
`ifdef PS2_ASCII_EN
            key_ascii_d = ext_pend_q ? 8'h00 : to_ascii(byte_q);
`else
            key_ascii_d = 8'h00;
`endif
        end
    end

    // State and output registers; reset dominates every state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            byte_q       <= '0;
            ext_pend_q   <= 1'b0;
            brk_pend_q   <= 1'b0;
            held_code_q  <= '0;
            held_ext_q   <= 1'b0;
            nextdata_n_q <= 1'b1;
            key_valid_q  <= 1'b0;
            key_code_q   <= '0;
            key_ext_q    <= 1'b0;
            key_make_q   <= 1'b0;
            key_ascii_q  <= '0;
            key_down_q   <= 1'b0;
            press_cnt_q  <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            byte_q       <= byte_d;
            ext_pend_q   <= ext_pend_d;
            brk_pend_q   <= brk_pend_d;
            held_code_q  <= held_code_d;
            held_ext_q   <= held_ext_d;
            nextdata_n_q <= nextdata_n_d;
            key_valid_q  <= key_valid_d;
            key_code_q   <= key_code_d;
            key_ext_q    <= key_ext_d;
            key_make_q   <= key_make_d;
            key_ascii_q  <= key_ascii_d;
            key_down_q   <= key_down_d;
            press_cnt_q  <= press_cnt_d;
            err_q        <= err_d;
        end
    end

    // Masking with rst keeps a latched-but-unpopped byte in the FIFO when
    // reset arrives during POP.
    assign nextdata_n = nextdata_n_q | rst;
    assign key_valid  = key_valid_q;
    assign key_code   = key_code_q;
    assign key_ext    = key_ext_q;
    assign key_make   = key_make_q;
    assign key_ascii  = key_ascii_q;
    assign key_down   = key_down_q;
    assign press_cnt  = press_cnt_q;
    assign err        = err_q;

endmodule
